// File: rtl/busx_pkg.sv
// rtl/busx_pkg.sv - opcodes, FSM encoding and index width for bus_xfer_unit
package busx_pkg;

    localparam int IDX_W = 4;

    typedef enum logic [2:0] {
        OP_NOP    = 3'd0,
        OP_LOAD   = 3'd1,
        OP_STORE  = 3'd2,
        OP_MOVE   = 3'd3,
        OP_ACC    = 3'd4,
        OP_ACCW   = 3'd5,
        OP_CLRACC = 3'd6,
        OP_RSV    = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic logic op_uses_src(input op_e op);
        return (op == OP_STORE) || (op == OP_MOVE) || (op == OP_ACC);
    endfunction

    function automatic logic op_uses_dst(input op_e op);
        return (op == OP_LOAD) || (op == OP_MOVE) || (op == OP_ACCW);
    endfunction

    // An index only matters when the opcode actually touches that register.
    function automatic logic cmd_legal(input op_e op, input logic [IDX_W-1:0] src,
                                       input logic [IDX_W-1:0] dst, input int n);
        logic ok;
        ok = (op != OP_RSV);
        if (op_uses_src(op) && (int'(src) >= n)) ok = 1'b0;
        if (op_uses_dst(op) && (int'(dst) >= n)) ok = 1'b0;
        return ok;
    endfunction

endpackage

// File: rtl/busx_reg.sv
// rtl/busx_reg.sv - one W-bit datapath register with write enable
module busx_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         we_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
        end else if (we_i) begin
            data_q <= d_i;
        end
    end

    assign q_o = data_q;

endmodule

// File: rtl/bus_xfer_unit.sv
// rtl/bus_xfer_unit.sv - N-register transfer unit with accumulator and bidirectional data port
// Optional BUSX_SAT_EN: accumulator saturates to all-ones on carry out instead of wrapping.
import busx_pkg::*;

module bus_xfer_unit #(
    parameter int W = 8,
    parameter int N = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [IDX_W-1:0] cmd_src,
    input  logic [IDX_W-1:0] cmd_dst,
    inout  wire  [W-1:0]     ext_dio,
    output logic             done,
    output logic             err,
    output logic [W-1:0]     rd_data,
    output logic [W-1:0]     acc_out,
    output logic             ovf
);

    state_e           state_q, state_d;
    op_e              op_q, op_d;
    logic [IDX_W-1:0] src_q, src_d;
    logic [IDX_W-1:0] dst_q, dst_d;
    logic [W-1:0]     acc_q, acc_d;
    logic             ovf_q, ovf_d;
    logic [W-1:0]     rd_q, rd_d;

    logic [W-1:0]     reg_q [N];
    logic [N-1:0]     reg_we;
    logic [W-1:0]     wr_data;
    logic             dst_we;
    logic [W-1:0]     bus;
    logic [W:0]       acc_sum;
    logic             legal;
    logic             xfer_ok;
    logic             drive_en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            op_q    <= OP_NOP;
            src_q   <= '0;
            dst_q   <= '0;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
            rd_q    <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
            rd_q    <= rd_d;
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        src_d   = src_q;
        dst_d   = dst_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    op_d    = op_e'(cmd_op);
                    src_d   = cmd_src;
                    dst_d   = cmd_dst;
                    state_d = ST_XFER;
                end
            end
            ST_XFER: state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign legal     = cmd_legal(op_q, src_q, dst_q, N);
    assign cmd_ready = (state_q == ST_IDLE);
    assign done      = (state_q == ST_DONE);
    assign err       = done && !legal;

    // The only bus source is the latched src register, so contention cannot occur.
    always_comb begin
        bus = '0;
        for (int i = 0; i < N; i++) begin
            if (src_q == IDX_W'(i)) bus = reg_q[i];
        end
    end

    assign acc_sum = {1'b0, acc_q} + {1'b0, bus};
    assign xfer_ok = (state_q == ST_XFER) && legal;

    always_comb begin
        acc_d   = acc_q;
        ovf_d   = ovf_q;
        rd_d    = rd_q;
        wr_data = '0;
        dst_we  = 1'b0;
        if (xfer_ok) begin
            case (op_q)
                OP_LOAD: begin
                    wr_data = ext_dio;
                    dst_we  = 1'b1;
                end
                OP_STORE: rd_d = bus;
                OP_MOVE: begin
                    wr_data = bus;
                    dst_we  = 1'b1;
                end
                OP_ACC: begin
`ifdef BUSX_SAT_EN
                    acc_d = acc_sum[W] ? {W{1'b1}} : acc_sum[W-1:0];
`else
                    acc_d = acc_sum[W-1:0];
`endif
                    ovf_d = ovf_q | acc_sum[W];
                end
                OP_ACCW: begin
                    wr_data = acc_q;
                    dst_we  = 1'b1;
                end
                OP_CLRACC: begin
                    acc_d = '0;
                    ovf_d = 1'b0;
                end
                default: ;
            endcase
        end
    end

    for (genvar g = 0; g < N; g++) begin : g_reg
        assign reg_we[g] = dst_we && (dst_q == IDX_W'(g));
        busx_reg #(.W(W)) u_reg (
            .clk   (clk),
            .rst_n (rst_n),
            .we_i  (reg_we[g]),
            .d_i   (wr_data),
            .q_o   (reg_q[g])
        );
    end

    // Drive enable comes straight from state_q, so reset releases the pins asynchronously.
    assign drive_en = ((state_q == ST_XFER) || (state_q == ST_DONE)) && legal && (op_q == OP_STORE);
    assign ext_dio  = drive_en ? bus : {W{1'bz}};

    assign rd_data = rd_q;
    assign acc_out = acc_q;
    assign ovf     = ovf_q;

endmodule

// File: tb/tb_bus_xfer_unit.sv
// tb/tb_bus_xfer_unit.sv - directed scoreboard bench for bus_xfer_unit
module tb_bus_xfer_unit;
    import busx_pkg::*;

    localparam int W = 8;
    localparam int N = 4;
    localparam logic [W-1:0] RELEASED = {W{1'b1}};

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         cmd_valid = 1'b0;
    logic [2:0]   cmd_op = 3'd0;
    logic [3:0]   cmd_src = 4'd0;
    logic [3:0]   cmd_dst = 4'd0;
    tri1  [W-1:0] ext_dio;
    logic         tb_en = 1'b0;
    logic [W-1:0] tb_data = '0;
    logic         cmd_ready, done, err, ovf;
    logic [W-1:0] rd_data, acc_out;

    assign ext_dio = tb_en ? tb_data : {W{1'bz}};

    bus_xfer_unit #(.W(W), .N(N)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_src(cmd_src), .cmd_dst(cmd_dst), .ext_dio(ext_dio),
        .done(done), .err(err), .rd_data(rd_data), .acc_out(acc_out), .ovf(ovf)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic         err;
        logic [W-1:0] rd;
        logic [W-1:0] acc;
        logic         ovf;
    } exp_t;

    exp_t         sb[$];
    int           checks = 0;
    int           errors = 0;
    int           cyc = 0;
    int           done_cnt = 0;
    logic [W-1:0] m_reg [N];
    logic [W-1:0] m_acc, m_rd;
    logic         m_ovf;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_reg[i] = '0;
        m_acc = '0;
        m_rd  = '0;
        m_ovf = 1'b0;
    endtask

    // Applies one command to the reference model; returns completion values and expected pins.
    task automatic model_cmd(input logic [2:0] op, input logic [3:0] src, input logic [3:0] dst,
                             input logic [W-1:0] data, output exp_t e, output logic [W-1:0] dio);
        logic   ok;
        logic [W:0] sum;
        ok  = (op != 3'd7);
        if ((op == 3'd2 || op == 3'd3 || op == 3'd4) && src >= N) ok = 1'b0;
        if ((op == 3'd1 || op == 3'd3 || op == 3'd5) && dst >= N) ok = 1'b0;
        dio = RELEASED;
        if (ok) begin
            case (op)
                3'd1: m_reg[dst] = data;
                3'd2: begin
                    m_rd = m_reg[src];
                    dio  = m_reg[src];
                end
                3'd3: m_reg[dst] = m_reg[src];
                3'd4: begin
                    sum = {1'b0, m_acc} + {1'b0, m_reg[src]};
`ifdef BUSX_SAT_EN
                    m_acc = sum[W] ? {W{1'b1}} : sum[W-1:0];
`else
                    m_acc = sum[W-1:0];
`endif
                    if (sum[W]) m_ovf = 1'b1;
                end
                3'd5: m_reg[dst] = m_acc;
                3'd6: begin
                    m_acc = '0;
                    m_ovf = 1'b0;
                end
                default: ;
            endcase
        end
        e.err = !ok;
        e.rd  = m_rd;
        e.acc = m_acc;
        e.ovf = m_ovf;
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n && done) begin
            exp_t e;
            done_cnt = done_cnt + 1;
            if (sb.size() == 0) begin
                check("sb_unexpected_done", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check("sb_err", 32'(err), 32'(e.err));
                check("sb_rd_data", 32'(rd_data), 32'(e.rd));
                check("sb_acc", 32'(acc_out), 32'(e.acc));
                check("sb_ovf", 32'(ovf), 32'(e.ovf));
            end
        end
    end

    task automatic do_cmd(input logic [2:0] op, input logic [3:0] src, input logic [3:0] dst,
                          input logic [W-1:0] data);
        exp_t         e;
        logic [W-1:0] dio;
        int           n;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_src   = src;
        cmd_dst   = dst;
        if (op == 3'd1) begin
            tb_en   = 1'b1;
            tb_data = data;
        end
        n = 0;
        while (!cmd_ready && n < 10) begin
            @(negedge clk);
            n++;
        end
        if (n >= 10) check("accept_timeout", 32'd1, 32'd0);
        model_cmd(op, src, dst, data, e, dio);
        sb.push_back(e);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        check("xfer_done_low", 32'(done), 32'd0);
        check("xfer_ready_low", 32'(cmd_ready), 32'd0);
        if (op != 3'd1) check("xfer_ext_dio", 32'(ext_dio), 32'(dio));
        @(posedge clk);
        #1;
        check("done_pulse", 32'(done), 32'd1);
        if (op != 3'd1) check("done_ext_dio", 32'(ext_dio), 32'(dio));
        tb_en = 1'b0;
        @(posedge clk);
        #1;
        check("after_done_low", 32'(done), 32'd0);
        check("after_ready_high", 32'(cmd_ready), 32'd1);
        check("after_ext_released", 32'(ext_dio), 32'(RELEASED));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int           acc_cyc [3];
        int           d0, n;
        exp_t         e;
        logic [W-1:0] dio;
        logic [2:0]   bop [3];
        logic [3:0]   bsrc [3];
        logic [3:0]   bdst [3];

        model_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", 32'(cmd_ready), 32'd1);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_rd_data", 32'(rd_data), 32'd0);
        check("rst_acc", 32'(acc_out), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        check("rst_ext_dio", 32'(ext_dio), 32'(RELEASED));
        @(negedge clk);
        rst_n = 1'b1;

        do_cmd(3'd1, 4'd0, 4'd2, 8'hA5);
        do_cmd(3'd2, 4'd2, 4'd0, 8'h00);
        do_cmd(3'd3, 4'd2, 4'd0, 8'h00);
        do_cmd(3'd2, 4'd0, 4'd0, 8'h00);
        do_cmd(3'd1, 4'd0, 4'd1, 8'h3C);
        do_cmd(3'd3, 4'd1, 4'd1, 8'h00);
        do_cmd(3'd2, 4'd1, 4'd0, 8'h00);
        do_cmd(3'd0, 4'd0, 4'd0, 8'h00);

        do_cmd(3'd1, 4'd0, 4'd0, 8'hF0);
        do_cmd(3'd1, 4'd0, 4'd1, 8'h20);
        do_cmd(3'd6, 4'd0, 4'd0, 8'h00);
        do_cmd(3'd4, 4'd0, 4'd0, 8'h00);
        do_cmd(3'd4, 4'd1, 4'd0, 8'h00);
        do_cmd(3'd5, 4'd0, 4'd3, 8'h00);
        do_cmd(3'd2, 4'd3, 4'd0, 8'h00);
        do_cmd(3'd6, 4'd0, 4'd0, 8'h00);

        do_cmd(3'd1, 4'd0, 4'd5, 8'h77);
        do_cmd(3'd7, 4'd1, 4'd2, 8'h00);
        do_cmd(3'd2, 4'd9, 4'd0, 8'h00);
        do_cmd(3'd3, 4'd1, 4'd15, 8'h00);
        do_cmd(3'd2, 4'd2, 4'd0, 8'h00);

        bop[0] = 3'd3; bsrc[0] = 4'd0; bdst[0] = 4'd1;
        bop[1] = 3'd4; bsrc[1] = 4'd2; bdst[1] = 4'd0;
        bop[2] = 3'd2; bsrc[2] = 4'd1; bdst[2] = 4'd0;
        d0 = done_cnt;
        @(negedge clk);
        cmd_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cmd_op  = bop[k];
            cmd_src = bsrc[k];
            cmd_dst = bdst[k];
            n = 0;
            while (!cmd_ready && n < 10) begin
                @(negedge clk);
                n++;
            end
            if (n >= 10) check("b2b_accept_timeout", 32'd1, 32'd0);
            model_cmd(bop[k], bsrc[k], bdst[k], '0, e, dio);
            sb.push_back(e);
            @(posedge clk);
            acc_cyc[k] = cyc;
            #1;
        end
        cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("b2b_spacing_1", 32'(acc_cyc[1] - acc_cyc[0]), 32'd3);
        check("b2b_spacing_2", 32'(acc_cyc[2] - acc_cyc[1]), 32'd3);
        check("b2b_done_count", 32'(done_cnt - d0), 32'd3);
        check("b2b_sb_drained", 32'(sb.size()), 32'd0);

        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = 3'd2;
        cmd_src   = 4'd2;
        cmd_dst   = 4'd0;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        check("rstmid_ext_driven", 32'(ext_dio), 32'(m_reg[2]));
        #2;
        rst_n = 1'b0;
        #1;
        check("rstmid_ext_released", 32'(ext_dio), 32'(RELEASED));
        check("rstmid_done", 32'(done), 32'd0);
        check("rstmid_ready", 32'(cmd_ready), 32'd1);
        check("rstmid_acc", 32'(acc_out), 32'd0);
        check("rstmid_ovf", 32'(ovf), 32'd0);
        check("rstmid_rd_data", 32'(rd_data), 32'd0);
        sb.delete();
        model_reset();
        d0 = done_cnt;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("rstmid_no_done", 32'(done_cnt - d0), 32'd0);
        do_cmd(3'd2, 4'd2, 4'd0, 8'h00);
        do_cmd(3'd2, 4'd0, 4'd0, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
